cache_controller_dm: RTL and testbench
======================================

# cache_controller_dm

Direct-mapped, write-back, write-allocate cache controller that sequences one `cache_memory` data array. It sits between a single word-granular requester (the core/fetch stage) and a block-granular main-memory port. It holds the tag, valid and dirty state, and decides hit or miss. It drives the data array's word and block write enables, and runs writeback and fill transactions.

## Interface
Parameters:
- BW_DATA, 32, bits per word
- N_BLOCKS, 64, cache lines; power of two
- N_WORDS_PER_BLOCK, 4, words per line; power of two
- BW_ADDR_WORD, 24, requester word-address width
- Derived: BW_OFFSET=CLOG2(N_WORDS_PER_BLOCK), BW_INDEX=CLOG2(N_BLOCKS), BW_TAG=BW_ADDR_WORD-BW_INDEX-BW_OFFSET, BW_BLOCK=BW_DATA*N_WORDS_PER_BLOCK, BW_ADDR_BLOCK=BW_ADDR_WORD-BW_OFFSET

Ports:
- clock_i  in  1  sole clock; one clock domain, all state on rising edge
- reset_i  in  1  asynchronous, active-high reset
- req_i  in  1  request strobe; accepted only when req_ready_o=1
- req_wren_i  in  1  1=write word, 0=read word
- req_addr_i  in  BW_ADDR_WORD  word address {tag,index,offset}
- req_data_i  in  BW_DATA  write data
- req_ready_o  out  1  controller idle, can accept a request
- req_valid_o  out  1  one-cycle completion pulse (read data or write ack)
- req_data_o  out  BW_DATA  read data; valid only with req_valid_o
- cm_wren_word_o  out  1  data-array single-word write
- cm_wren_block_o  out  1  data-array full-line write
- cm_addr_o  out  BW_INDEX  data-array line index
- cm_offset_o  out  BW_OFFSET  data-array word select
- cm_data_block_o  out  BW_BLOCK  data-array write bus; in word mode the word sits in bits [BW_DATA-1:0]
- cm_data_word_i  in  BW_DATA  data-array word read; registered, 1-cycle latency
- cm_data_block_i  in  BW_BLOCK  data-array line read; registered, 1-cycle latency
- mem_req_o  out  1  main-memory transaction request; held until mem_done_i
- mem_wren_o  out  1  1=writeback, 0=fill read
- mem_addr_o  out  BW_ADDR_BLOCK  block address {tag,index}
- mem_data_o  out  BW_BLOCK  writeback line
- mem_done_i  in  1  one-cycle transaction complete; fill data on mem_data_i this cycle
- mem_data_i  in  BW_BLOCK  fill line

## Operation
States: IDLE, LOOKUP, WRITEBACK, FILL, REPLAY.

- **IDLE**
  - req_ready_o=1.
  - cm_addr_o is driven combinationally from req_addr_i index, which issues the array read.
  - On req_i: latch wren, tag, index, offset and data; go to LOOKUP.
- **LOOKUP**
  - hit = valid[idx] & (tag_store[idx]==tag).
  - Read hit: req_valid_o=1, req_data_o=cm_data_word_i; go to IDLE.
  - Write hit: cm_wren_word_o=1, cm_data_block_o[BW_DATA-1:0]=latched data; set dirty[idx]; req_valid_o=1; go to IDLE.
  - Miss with valid & dirty: latch cm_data_block_i and the old tag into the writeback buffer; go to WRITEBACK.
  - Any other miss: go to FILL.
- **WRITEBACK**
  - mem_req_o=1, mem_wren_o=1, mem_addr_o={old tag,idx}, mem_data_o=buffer.
  - On mem_done_i: go to FILL.
- **FILL**
  - mem_req_o=1, mem_wren_o=0, mem_addr_o={tag,idx}.
  - On mem_done_i: cm_wren_block_o=1, cm_data_block_o=mem_data_i; set valid=1, tag, dirty=0; go to REPLAY.
- **REPLAY**
  - Hold cm_addr_o=idx, which re-reads the line; go to LOOKUP.
  - The request then completes as a hit.

Rules:
- Outside IDLE, cm_addr_o and cm_offset_o equal the latched index and offset.
- cm_wren_word_o and cm_wren_block_o are never high together.
- Tag is compared at full BW_TAG width.
- mem_done_i is ignored outside WRITEBACK/FILL.
- req_i is ignored while req_ready_o=0.

## Timing
- Reset state:
  - IDLE; all valid and dirty bits cleared.
  - req_ready_o=1; every other output 0.
- Hit: accept in cycle 0; req_valid_o in cycle 1.
- Clean miss: FILL from cycle 2, mem_done_i in cycle k, REPLAY in k+1, req_valid_o in k+2.
- Dirty miss: adds the WRITEBACK duration before FILL.
- mem_done_i in the same cycle as entering WRITEBACK/FILL is legal and takes effect that cycle.
- Reset mid-transaction:
  - mem_req_o drops asynchronously and the request is abandoned.
  - Dirty data is discarded; requester and memory must also be reset.
- A request arriving in the same cycle as req_valid_o is not accepted; the next acceptance is in IDLE.

## Structure
- The shared cache package/header holds:
  - state encodings (localparam, 3 bits);
  - the address-field split (tag/index/offset) helper.
- Width derivations use the existing `CLOG2` macro.
- One sub-module: cache_tag_store, holding the valid/dirty/tag flop arrays.
  - Combinational read by index.
  - Synchronous set and clear ports.
  - Asynchronous clear on reset_i.
- The data array itself is an external cache_memory instance, wired at the parent.

## Test plan
Parameters: BW_DATA=32, N_BLOCKS=4, N_WORDS_PER_BLOCK=4, BW_ADDR_WORD=8. Memory model returns fill word w = {addr_block,w}.

- **Cold read miss:** read 0x15 (tag1, idx1, off1); mem_done_i 3 cycles after mem_req_o → mem_addr_o=0x05, mem_wren_o=0, cm_wren_block_o one pulse, req_valid_o with req_data_o={0x05,1}.
- **Read hit:** repeat read 0x15 → req_valid_o exactly 1 cycle after acceptance, same data, mem_req_o stays 0.
- **Write hit then dirty eviction:** write 0x16=0xDEADBEEF, then read 0x56 (tag5, idx1) → WRITEBACK to mem_addr_o=0x05 with word2=0xDEADBEEF, then FILL from 0x15; response data {0x15,2}.
- **Write miss allocate:** write 0x20=0x12345678 on a cold line → fill from 0x08, then word write; a subsequent read of 0x20 returns 0x12345678 as a hit.
- **Reset mid-FILL:** assert reset_i during FILL → mem_req_o=0 immediately, req_ready_o=1 after release, read 0x15 misses again.
- **Back-pressure:** req_i held high during a miss → exactly one transaction is issued; req_i is ignored until req_ready_o=1.

Source files
------------

// File: rtl/cache_controller_dm_pkg.sv
// Shared definitions for the direct-mapped cache controller: state encodings,
// the width helper macro and the word-address field splitter.
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

package cache_controller_dm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOOKUP    = 3'd1,
        ST_WRITEBACK = 3'd2,
        ST_FILL      = 3'd3,
        ST_REPLAY    = 3'd4
    } state_e;

    localparam int unsigned BW_ADDR_MAX = 64;

    // Extract a field of `width` bits starting at bit `lsb` of a word address.
    function automatic logic [BW_ADDR_MAX-1:0] addr_field(
        input logic [BW_ADDR_MAX-1:0] addr,
        input int unsigned            lsb,
        input int unsigned            width
    );
        logic [BW_ADDR_MAX-1:0] mask;
        mask = (BW_ADDR_MAX'(1) << width) - BW_ADDR_MAX'(1);
        return (addr >> lsb) & mask;
    endfunction

endpackage

// File: rtl/cache_controller_dm_tag_store.sv
// Per-line valid/dirty/tag flops with combinational read by index and
// synchronous fill / mark-dirty updates; reset invalidates every line.
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

module cache_controller_dm_tag_store #(
    parameter int unsigned  N_BLOCKS = 64,
    parameter int unsigned  BW_TAG   = 16,
    localparam int unsigned BW_INDEX = `CLOG2(N_BLOCKS)
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic [BW_INDEX-1:0] rd_idx_i,
    output logic                rd_valid_o,
    output logic                rd_dirty_o,
    output logic [BW_TAG-1:0]   rd_tag_o,
    input  logic [BW_INDEX-1:0] wr_idx_i,
    input  logic                fill_i,
    input  logic [BW_TAG-1:0]   fill_tag_i,
    input  logic                set_dirty_i
);

    logic [N_BLOCKS-1:0] valid_q;
    logic [N_BLOCKS-1:0] dirty_q;
    logic [BW_TAG-1:0]   tag_q [N_BLOCKS];

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_dirty_o = dirty_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];

    // A fill installs a clean line; a write hit only marks it dirty.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            valid_q <= '0;
            dirty_q <= '0;
            for (int i = 0; i < int'(N_BLOCKS); i++) begin
                tag_q[i] <= '0;
            end
        end else if (fill_i) begin
            valid_q[wr_idx_i] <= 1'b1;
            dirty_q[wr_idx_i] <= 1'b0;
            tag_q[wr_idx_i]   <= fill_tag_i;
        end else if (set_dirty_i) begin
            dirty_q[wr_idx_i] <= 1'b1;
        end
    end

endmodule

// File: rtl/cache_controller_dm.sv
// Direct-mapped write-back / write-allocate cache controller sequencing an
// external data array between a word requester and a block memory port.
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

module cache_controller_dm
    import cache_controller_dm_pkg::*;
#(
    parameter int unsigned  BW_DATA           = 32,
    parameter int unsigned  N_BLOCKS          = 64,
    parameter int unsigned  N_WORDS_PER_BLOCK = 4,
    parameter int unsigned  BW_ADDR_WORD      = 24,
    localparam int unsigned BW_OFFSET     = `CLOG2(N_WORDS_PER_BLOCK),
    localparam int unsigned BW_INDEX      = `CLOG2(N_BLOCKS),
    localparam int unsigned BW_TAG        = BW_ADDR_WORD - BW_INDEX - BW_OFFSET,
    localparam int unsigned BW_BLOCK      = BW_DATA * N_WORDS_PER_BLOCK,
    localparam int unsigned BW_ADDR_BLOCK = BW_ADDR_WORD - BW_OFFSET
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     req_i,
    input  logic                     req_wren_i,
    input  logic [BW_ADDR_WORD-1:0]  req_addr_i,
    input  logic [BW_DATA-1:0]       req_data_i,
    output logic                     req_ready_o,
    output logic                     req_valid_o,
    output logic [BW_DATA-1:0]       req_data_o,
    output logic                     cm_wren_word_o,
    output logic                     cm_wren_block_o,
    output logic [BW_INDEX-1:0]      cm_addr_o,
    output logic [BW_OFFSET-1:0]     cm_offset_o,
    output logic [BW_BLOCK-1:0]      cm_data_block_o,
    input  logic [BW_DATA-1:0]       cm_data_word_i,
    input  logic [BW_BLOCK-1:0]      cm_data_block_i,
    output logic                     mem_req_o,
    output logic                     mem_wren_o,
    output logic [BW_ADDR_BLOCK-1:0] mem_addr_o,
    output logic [BW_BLOCK-1:0]      mem_data_o,
    input  logic                     mem_done_i,
    input  logic [BW_BLOCK-1:0]      mem_data_i
);

    state_e                state_q;
    logic                  wren_q;
    logic [BW_TAG-1:0]     tag_q;
    logic [BW_INDEX-1:0]   idx_q;
    logic [BW_OFFSET-1:0]  off_q;
    logic [BW_DATA-1:0]    wdata_q;
    logic [BW_TAG-1:0]     wb_tag_q;
    logic [BW_BLOCK-1:0]   wb_data_q;

    logic [BW_TAG-1:0]     req_tag;
    logic [BW_INDEX-1:0]   req_idx;
    logic [BW_OFFSET-1:0]  req_off;
    logic                  ts_valid;
    logic                  ts_dirty;
    logic [BW_TAG-1:0]     ts_tag;
    logic                  hit;
    logic                  fill_done;
    logic                  set_dirty;

    assign req_off = BW_OFFSET'(addr_field(BW_ADDR_MAX'(req_addr_i), 0, BW_OFFSET));
    assign req_idx = BW_INDEX'(addr_field(BW_ADDR_MAX'(req_addr_i), BW_OFFSET, BW_INDEX));
    assign req_tag = BW_TAG'(addr_field(BW_ADDR_MAX'(req_addr_i), BW_OFFSET + BW_INDEX, BW_TAG));

    assign hit       = ts_valid && (ts_tag == tag_q);
    assign fill_done = (state_q == ST_FILL) && mem_done_i;
    assign set_dirty = (state_q == ST_LOOKUP) && hit && wren_q;

    cache_controller_dm_tag_store #(
        .N_BLOCKS (N_BLOCKS),
        .BW_TAG   (BW_TAG)
    ) u_tag_store (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .rd_idx_i    (idx_q),
        .rd_valid_o  (ts_valid),
        .rd_dirty_o  (ts_dirty),
        .rd_tag_o    (ts_tag),
        .wr_idx_i    (idx_q),
        .fill_i      (fill_done),
        .fill_tag_i  (tag_q),
        .set_dirty_i (set_dirty)
    );

    // Sequencer and request/writeback latches.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            wren_q    <= 1'b0;
            tag_q     <= '0;
            idx_q     <= '0;
            off_q     <= '0;
            wdata_q   <= '0;
            wb_tag_q  <= '0;
            wb_data_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_i) begin
                        wren_q  <= req_wren_i;
                        tag_q   <= req_tag;
                        idx_q   <= req_idx;
                        off_q   <= req_off;
                        wdata_q <= req_data_i;
                        state_q <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (hit) begin
                        state_q <= ST_IDLE;
                    end else if (ts_valid && ts_dirty) begin
                        wb_tag_q  <= ts_tag;
                        wb_data_q <= cm_data_block_i;
                        state_q   <= ST_WRITEBACK;
                    end else begin
                        state_q <= ST_FILL;
                    end
                end
                ST_WRITEBACK: begin
                    if (mem_done_i) begin
                        state_q <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (mem_done_i) begin
                        state_q <= ST_REPLAY;
                    end
                end
                ST_REPLAY: state_q <= ST_LOOKUP;
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

    // Output decode; the array address follows the requester only while idle.
    always_comb begin
        req_ready_o     = 1'b0;
        req_valid_o     = 1'b0;
        req_data_o      = '0;
        cm_wren_word_o  = 1'b0;
        cm_wren_block_o = 1'b0;
        cm_addr_o       = idx_q;
        cm_offset_o     = off_q;
        cm_data_block_o = '0;
        mem_req_o       = 1'b0;
        mem_wren_o      = 1'b0;
        mem_addr_o      = '0;
        mem_data_o      = '0;
        case (state_q)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                cm_addr_o   = req_idx;
                cm_offset_o = req_off;
            end
            ST_LOOKUP: begin
                if (hit) begin
                    req_valid_o = 1'b1;
                    if (wren_q) begin
                        cm_wren_word_o  = 1'b1;
                        cm_data_block_o = BW_BLOCK'(wdata_q);
                    end else begin
                        req_data_o = cm_data_word_i;
                    end
                end
            end
            ST_WRITEBACK: begin
                mem_req_o  = 1'b1;
                mem_wren_o = 1'b1;
                mem_addr_o = {wb_tag_q, idx_q};
                mem_data_o = wb_data_q;
            end
            ST_FILL: begin
                mem_req_o  = 1'b1;
                mem_addr_o = {tag_q, idx_q};
                if (mem_done_i) begin
                    cm_wren_block_o = 1'b1;
                    cm_data_block_o = mem_data_i;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_controller_dm.sv
// Self-checking bench for cache_controller_dm: directed scenarios followed by
// random traffic, checked against a flat-memory plus line-state reference.
`timescale 1ns/1ps

module tb_cache_controller_dm;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_i, req_wren_i;
    logic [7:0]   req_addr_i;
    logic [31:0]  req_data_i;
    logic         req_ready_o, req_valid_o;
    logic [31:0]  req_data_o;
    logic         cm_wren_word_o, cm_wren_block_o;
    logic [1:0]   cm_addr_o, cm_offset_o;
    logic [127:0] cm_data_block_o;
    logic [31:0]  cm_data_word_i;
    logic [127:0] cm_data_block_i;
    logic         mem_req_o, mem_wren_o;
    logic [5:0]   mem_addr_o;
    logic [127:0] mem_data_o;
    logic         mem_done_i;
    logic [127:0] mem_data_i;

    always #5 clk = ~clk;

    cache_controller_dm #(
        .BW_DATA(32), .N_BLOCKS(4), .N_WORDS_PER_BLOCK(4), .BW_ADDR_WORD(8)
    ) dut (
        .clock_i(clk), .reset_i(rst),
        .req_i(req_i), .req_wren_i(req_wren_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
        .req_ready_o(req_ready_o), .req_valid_o(req_valid_o), .req_data_o(req_data_o),
        .cm_wren_word_o(cm_wren_word_o), .cm_wren_block_o(cm_wren_block_o),
        .cm_addr_o(cm_addr_o), .cm_offset_o(cm_offset_o), .cm_data_block_o(cm_data_block_o),
        .cm_data_word_i(cm_data_word_i), .cm_data_block_i(cm_data_block_i),
        .mem_req_o(mem_req_o), .mem_wren_o(mem_wren_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_done_i(mem_done_i), .mem_data_i(mem_data_i)
    );

    // Data array: registered reads with one-cycle latency.
    logic [31:0] cmem [16];
    always @(posedge clk) begin
        if (cm_wren_block_o) begin
            for (int w = 0; w < 4; w++) cmem[{cm_addr_o, 2'(w)}] <= cm_data_block_o[w*32 +: 32];
        end else if (cm_wren_word_o) begin
            cmem[{cm_addr_o, cm_offset_o}] <= cm_data_block_o[31:0];
        end
        cm_data_word_i <= cmem[{cm_addr_o, cm_offset_o}];
        for (int w = 0; w < 4; w++) cm_data_block_i[w*32 +: 32] <= cmem[{cm_addr_o, 2'(w)}];
    end

    // Main memory contents and the architectural view seen by the requester.
    logic [31:0] bmem    [256];
    logic [31:0] ref_mem [256];
    logic        mv [4];
    logic        md [4];
    logic [3:0]  mt [4];

    always_comb begin
        for (int w = 0; w < 4; w++) mem_data_i[w*32 +: 32] = bmem[{mem_addr_o, 2'(w)}];
    end

    int checks = 0;
    int passed = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mv[i] = 1'b0;
            md[i] = 1'b0;
            mt[i] = 4'd0;
        end
        for (int i = 0; i < 256; i++) ref_mem[i] = bmem[i];
    endtask

    // One request; memory answers `dly` cycles after each mem_req_o start
    // (dly=0 keeps mem_done_i high throughout, including idle cycles).
    task automatic do_req(input logic wr, input logic [7:0] a, input logic [31:0] d,
                          input int dly, input bit hold);
        logic [3:0]   tg;
        logic [1:0]   ix, of;
        bit           exp_hit, exp_wb, got, both, busy_ready, wword;
        int           exp_lat, lat, n_txn, n_bfill, n_seen;
        logic [5:0]   wb_addr, fill_addr;
        logic [127:0] wb_data, wb_exp;
        logic [31:0]  rdata, wdat;
        logic [1:0]   woff, waddr;
        tg = a[7:4]; ix = a[3:2]; of = a[1:0];
        exp_hit = mv[ix] && (mt[ix] == tg);
        exp_wb  = !exp_hit && mv[ix] && md[ix];
        exp_lat = exp_hit ? 1 : (exp_wb ? 5 + 2*dly : 4 + dly);
        for (int w = 0; w < 4; w++) wb_exp[w*32 +: 32] = ref_mem[{mt[ix], ix, 2'(w)}];
        got = 0; both = 0; busy_ready = 0; wword = 0;
        lat = 0; n_txn = 0; n_bfill = 0; n_seen = 0;
        wb_addr = '0; fill_addr = '0; wb_data = '0; rdata = '0; wdat = '0; woff = '0; waddr = '0;

        req_i = 1'b1; req_wren_i = wr; req_addr_i = a; req_data_i = d;
        mem_done_i = (dly == 0);
        @(negedge clk);
        chk("ready_before_accept", 128'(req_ready_o), 128'(1));
        @(posedge clk); #1;
        if (hold) begin
            req_addr_i = 8'($urandom); req_data_i = $urandom; req_wren_i = 1'($urandom);
        end else begin
            req_i = 1'b0;
        end
        while (!got && lat < 100) begin
            lat++;
            @(negedge clk);
            if (req_ready_o) busy_ready = 1;
            if (cm_wren_word_o && cm_wren_block_o) both = 1;
            if (cm_wren_block_o) n_bfill++;
            if (mem_req_o) begin
                n_seen++;
                if (mem_done_i) begin
                    n_txn++;
                    n_seen = 0;
                    if (mem_wren_o) begin
                        wb_addr = mem_addr_o;
                        wb_data = mem_data_o;
                        for (int w = 0; w < 4; w++) bmem[{mem_addr_o, 2'(w)}] = mem_data_o[w*32 +: 32];
                    end else begin
                        fill_addr = mem_addr_o;
                    end
                end
            end
            if (req_valid_o) begin
                got = 1; rdata = req_data_o; wword = cm_wren_word_o;
                wdat = cm_data_block_o[31:0]; woff = cm_offset_o; waddr = cm_addr_o;
                req_i = 1'b0;
            end
            @(posedge clk); #1;
            mem_done_i = (dly == 0) || (n_seen == dly);
        end
        mem_done_i = 1'b0;

        chk("completion", 128'(got), 128'(1));
        chk("latency", 128'(lat), 128'(exp_lat));
        chk("mem_txn_count", 128'(n_txn), 128'(exp_hit ? 0 : (exp_wb ? 2 : 1)));
        chk("block_write_pulses", 128'(n_bfill), 128'(exp_hit ? 0 : 1));
        chk("wren_exclusive", 128'(both), 128'(0));
        chk("ready_low_while_busy", 128'(busy_ready), 128'(0));
        chk("cm_addr_at_done", 128'(waddr), 128'(ix));
        if (!exp_hit) chk("fill_addr", 128'(fill_addr), 128'({tg, ix}));
        if (exp_wb) begin
            chk("wb_addr", 128'(wb_addr), 128'({mt[ix], ix}));
            chk("wb_data", wb_data, wb_exp);
        end
        if (wr) begin
            chk("word_write", 128'(wword), 128'(1));
            chk("word_write_data", 128'(wdat), 128'(d));
            chk("word_write_offset", 128'(woff), 128'(of));
        end else begin
            chk("read_data", 128'(rdata), 128'(ref_mem[a]));
        end

        if (!exp_hit) begin
            mv[ix] = 1'b1; mt[ix] = tg; md[ix] = 1'b0;
        end
        if (wr) begin
            md[ix] = 1'b1; ref_mem[a] = d;
        end
    endtask

    initial begin
        bit seen;
        for (int i = 0; i < 256; i++) bmem[i] = 32'((i >> 2) << 8) | 32'(i & 3);
        model_reset();
        rst = 1'b1; req_i = 1'b0; req_wren_i = 1'b0; req_addr_i = '0; req_data_i = '0;
        mem_done_i = 1'b0;

        // Reset state
        #2;
        chk("rst_ready", 128'(req_ready_o), 128'(1));
        chk("rst_valid", 128'(req_valid_o), 128'(0));
        chk("rst_rdata", 128'(req_data_o), 128'(0));
        chk("rst_cm_wren", 128'({cm_wren_word_o, cm_wren_block_o}), 128'(0));
        chk("rst_cm_bus", 128'({cm_addr_o, cm_offset_o}) | cm_data_block_o, 128'(0));
        chk("rst_mem_ctl", 128'({mem_req_o, mem_wren_o, mem_addr_o}), 128'(0));
        chk("rst_mem_data", mem_data_o, 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed scenarios
        do_req(1'b0, 8'h15, 32'h0, 3, 0);             // cold read miss
        do_req(1'b0, 8'h15, 32'h0, 3, 0);             // read hit
        do_req(1'b1, 8'h16, 32'hDEADBEEF, 2, 0);      // write hit
        do_req(1'b0, 8'h56, 32'h0, 2, 0);             // dirty eviction
        do_req(1'b1, 8'h20, 32'h12345678, 1, 0);      // write miss allocate
        do_req(1'b0, 8'h20, 32'h0, 1, 0);             // read back as hit
        do_req(1'b0, 8'h3C, 32'h0, 0, 0);             // done asserted on entry to FILL
        do_req(1'b0, 8'hA8, 32'h0, 2, 1);             // back-pressure: req_i held

        // Reset during FILL
        req_i = 1'b1; req_wren_i = 1'b0; req_addr_i = 8'h15;
        @(posedge clk); #1;
        req_i = 1'b0;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = mem_req_o && !mem_wren_o;
        end
        chk("fill_started", 128'(seen), 128'(1));
        rst = 1'b1;
        #1;
        chk("rst_drops_mem_req", 128'(mem_req_o), 128'(0));
        chk("rst_ready_async", 128'(req_ready_o), 128'(1));
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        do_req(1'b0, 8'h15, 32'h0, 2, 0);             // misses again after reset

        // Random traffic over a few tags per line
        for (int n = 0; n < 80; n++) begin
            logic [7:0] a;
            a = {4'($urandom_range(0, 2)), 4'($urandom)};
            do_req(1'($urandom), a, $urandom, int'($urandom_range(0, 3)), $urandom_range(0, 7) == 0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
